// File: rtl/nn_engine_pkg.sv
// Shared definitions for the layer-sequenced MLP engine: activation codes,
// controller states and Q6.10 reference constants.
package nn_engine_pkg;

  // Per-layer activation select codes
  localparam logic [1:0] AF_IDENT     = 2'b00;
  localparam logic [1:0] AF_RELU      = 2'b01;
  localparam logic [1:0] AF_HTANH     = 2'b10;
  localparam logic [1:0] AF_IDENT_ALT = 2'b11;

  // Q6.10 reference points for the default 16-bit format
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_FRAC_W = 10;
  localparam logic signed [DEF_DATA_W-1:0] ONE     = 16'sh0400;
  localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    StIdle,
    StLoadX,
    StLoadB,
    StLoadW,
    StMac,
    StAct,
    StOut,
    StDone
  } state_e;

endpackage

// File: rtl/nn_layer_engine_if.sv
// Input, parameter and result valid/ready streams of the layer engine.
interface nn_layer_engine_if #(
  parameter int unsigned DATA_W = 16
);
  logic              x_valid;
  logic              x_ready;
  logic [DATA_W-1:0] x_data;
  logic              p_valid;
  logic              p_ready;
  logic [DATA_W-1:0] p_data;
  logic              y_valid;
  logic              y_ready;
  logic [DATA_W-1:0] y_data;
  logic              y_last;

  // Stream sources and result consumer
  modport master (
    output x_valid, x_data, p_valid, p_data, y_ready,
    input  x_ready, p_ready, y_valid, y_data, y_last
  );

  // Engine side
  modport slave (
    input  x_valid, x_data, p_valid, p_data, y_ready,
    output x_ready, p_ready, y_valid, y_data, y_last
  );
endinterface

// File: rtl/nn_mac_lane.sv
// One neuron lane: weight register, wide accumulator, and the
// round / saturate / activate path that produces the lane result.
module nn_mac_lane
  import nn_engine_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bias_load,
  input  logic                     w_load,
  input  logic                     mac_en,
  input  logic        [DATA_W-1:0] p_in,
  input  logic signed [DATA_W-1:0] act_in,
  input  logic        [1:0]        af,
  output logic signed [DATA_W-1:0] res
);

  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W-1);
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ONE_Q =
    {{(DATA_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [DATA_W-1:0] NEG_ONE_Q = -ONE_Q;

  logic signed [DATA_W-1:0]   w_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    rounded;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [DATA_W-1:0]   sat;

  // Product and bias alignment into the accumulator's Q.(2*FRAC_W) format
  always_comb begin
    prod     = w_q * act_in;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_ext = {{(ACC_W-DATA_W){p_in[DATA_W-1]}}, p_in} << FRAC_W;
  end

  // Weight register and accumulator; bias load restarts the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      acc_q <= '0;
    end else begin
      if (w_load) w_q <= p_in;
      if (bias_load) begin
        acc_q <= bias_ext;
      end else if (mac_en) begin
        acc_q <= acc_q + prod_ext;
      end
    end
  end

  // Round half up, saturate to DATA_W, then apply the layer activation
  always_comb begin
    rounded = acc_q + RND;
    shifted = rounded >>> FRAC_W;
    if (shifted > SAT_HI) begin
      sat = SAT_HI[DATA_W-1:0];
    end else if (shifted < SAT_LO) begin
      sat = SAT_LO[DATA_W-1:0];
    end else begin
      sat = shifted[DATA_W-1:0];
    end
    res = sat;
    case (af)
      AF_RELU:  res = sat[DATA_W-1] ? '0 : sat;
      AF_HTANH: begin
        if (sat > ONE_Q) begin
          res = ONE_Q;
        end else if (sat < NEG_ONE_Q) begin
          res = NEG_ONE_Q;
        end
      end
      default:  res = sat;
    endcase
  end

endmodule

// File: rtl/nn_layer_engine.sv
// Layer-sequenced fixed-point MLP engine: controller FSM, counters,
// ping-pong activation banks and stream control around MAX_N MAC lanes.
module nn_layer_engine
  import nn_engine_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_W     = 10,
  parameter int unsigned MAX_N      = 8,
  parameter int unsigned MAX_LAYERS = 4,
  parameter int unsigned ACC_W      = 2*DATA_W + $clog2(MAX_N) + 1,
  localparam int unsigned NW        = $clog2(MAX_N+1),
  localparam int unsigned LW        = $clog2(MAX_LAYERS+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LW-1:0]            cfg_layers,
  input  logic [NW-1:0]            cfg_nin,
  input  logic [MAX_LAYERS*NW-1:0] cfg_nneu,
  input  logic [2*MAX_LAYERS-1:0]  cfg_af,
  nn_layer_engine_if.slave         bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned IW  = $clog2(MAX_N);
  localparam int unsigned LIW = $clog2(MAX_LAYERS);

  state_e state_q, state_d;

  logic [LIW-1:0] layer_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  beat_q;
  logic           sel_q;
  logic           err_q;
  logic [LW-1:0]  layers_q;
  logic [NW-1:0]  nin0_q;
  logic [NW-1:0]  nneu_q [MAX_LAYERS];
  logic [1:0]     af_q   [MAX_LAYERS];

  logic signed [DATA_W-1:0] bank_q [2][MAX_N];
  logic signed [DATA_W-1:0] res    [MAX_N];

  logic              y_valid_q;
  logic [DATA_W-1:0] y_data_q;
  logic              y_last_q;

  logic                     cfg_ok;
  logic [NW-1:0]            cur_nneu;
  logic [NW-1:0]            cur_nin;
  logic                     beat_last_n;
  logic                     beat_last_x;
  logic                     idx_last;
  logic                     more_layers;
  logic                     x_hs, p_hs, y_hs;
  logic signed [DATA_W-1:0] act_mac;

  // Start-time config validation; only layers that will run are checked
  always_comb begin
    cfg_ok = 1'b1;
    if (cfg_layers == '0 || cfg_layers > LW'(MAX_LAYERS)) cfg_ok = 1'b0;
    if (cfg_nin == '0 || cfg_nin > NW'(MAX_N)) cfg_ok = 1'b0;
    for (int l = 0; l < MAX_LAYERS; l++) begin
      if (l < int'(cfg_layers)) begin
        if (cfg_nneu[l*NW +: NW] == '0 || cfg_nneu[l*NW +: NW] > NW'(MAX_N)) cfg_ok = 1'b0;
      end
    end
  end

  // Current layer geometry and beat/index terminal conditions
  always_comb begin
    cur_nneu    = nneu_q[layer_q];
    cur_nin     = (layer_q == '0) ? nin0_q : nneu_q[layer_q - LIW'(1)];
    beat_last_n = NW'(beat_q) == cur_nneu - NW'(1);
    beat_last_x = NW'(beat_q) == cur_nin - NW'(1);
    idx_last    = NW'(idx_q) == cur_nin - NW'(1);
    more_layers = (LW'(layer_q) + LW'(1)) < layers_q;
    act_mac     = bank_q[sel_q][idx_q];
    x_hs        = bus.x_valid && bus.x_ready;
    p_hs        = bus.p_valid && bus.p_ready;
    y_hs        = y_valid_q && bus.y_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d     = state_q;
    bus.x_ready = 1'b0;
    bus.p_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = cfg_ok ? StLoadX : StDone;
      end
      StLoadX: begin
        bus.x_ready = 1'b1;
        if (x_hs && beat_last_x) state_d = StLoadB;
      end
      StLoadB: begin
        bus.p_ready = 1'b1;
        if (p_hs && beat_last_n) state_d = StLoadW;
      end
      StLoadW: begin
        bus.p_ready = 1'b1;
        if (p_hs && beat_last_n) state_d = StMac;
      end
      StMac:   state_d = idx_last ? StAct : StLoadW;
      StAct:   state_d = more_layers ? StLoadB : StOut;
      StOut: begin
        if (y_hs && beat_last_n) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Config capture, counters and the registered result stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_q   <= '0;
      idx_q     <= '0;
      beat_q    <= '0;
      sel_q     <= 1'b0;
      err_q     <= 1'b0;
      layers_q  <= '0;
      nin0_q    <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      for (int l = 0; l < MAX_LAYERS; l++) begin
        nneu_q[l] <= '0;
        af_q[l]   <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            err_q    <= !cfg_ok;
            layers_q <= cfg_layers;
            nin0_q   <= cfg_nin;
            layer_q  <= '0;
            idx_q    <= '0;
            beat_q   <= '0;
            sel_q    <= 1'b0;
            for (int l = 0; l < MAX_LAYERS; l++) begin
              nneu_q[l] <= cfg_nneu[l*NW +: NW];
              af_q[l]   <= cfg_af[2*l +: 2];
            end
          end
        end
        StLoadX: if (x_hs) beat_q <= beat_last_x ? '0 : beat_q + IW'(1);
        StLoadB, StLoadW: if (p_hs) beat_q <= beat_last_n ? '0 : beat_q + IW'(1);
        StMac:   idx_q <= idx_last ? '0 : idx_q + IW'(1);
        StAct: begin
          // Results land in the opposite bank, which becomes the next input bank
          sel_q  <= !sel_q;
          beat_q <= '0;
          if (more_layers) begin
            layer_q <= layer_q + LIW'(1);
          end else begin
            y_valid_q <= 1'b1;
            y_data_q  <= res[0];
            y_last_q  <= cur_nneu == NW'(1);
          end
        end
        StOut: begin
          if (y_hs) begin
            if (beat_last_n) begin
              y_valid_q <= 1'b0;
              y_last_q  <= 1'b0;
            end else begin
              beat_q   <= beat_q + IW'(1);
              y_data_q <= bank_q[sel_q][beat_q + IW'(1)];
              y_last_q <= NW'(beat_q) + NW'(1) == cur_nneu - NW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Activation banks: inputs fill bank 0, each ACT writes the idle bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < MAX_N; j++) bank_q[b][j] <= '0;
      end
    end else if (state_q == StLoadX && x_hs) begin
      bank_q[sel_q][beat_q] <= bus.x_data;
    end else if (state_q == StAct) begin
      for (int j = 0; j < MAX_N; j++) begin
        if (NW'(j) < cur_nneu) bank_q[!sel_q][j] <= res[j];
      end
    end
  end

  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_last  = y_last_q;

  for (genvar j = 0; j < MAX_N; j++) begin : g_lane
    logic lane_on;
    assign lane_on = NW'(j) < cur_nneu;

    nn_mac_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .bias_load (state_q == StLoadB && p_hs && beat_q == IW'(j)),
      .w_load    (state_q == StLoadW && p_hs && beat_q == IW'(j)),
      .mac_en    (state_q == StMac && lane_on),
      .p_in      (bus.p_data),
      .act_in    (act_mac),
      .af        (af_q[layer_q]),
      .res       (res[j])
    );
  end

endmodule
